// File: rtl/index_frame_reader_pkg.sv
// Shared VGA 640x480@60 timing constants and the 8-entry colour palette used by
// the frame memory reader (and the writer-side address mapping).
package index_frame_reader_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Width of the horizontal and vertical position counters.
  localparam int unsigned CNT_W = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Index bit2 drives red, bit1 green, bit0 blue, each fully on or off.
  function automatic rgb_t palette(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'b000:  c = '{r: 8'h00, g: 8'h00, b: 8'h00};
      3'b001:  c = '{r: 8'h00, g: 8'h00, b: 8'hFF};
      3'b010:  c = '{r: 8'h00, g: 8'hFF, b: 8'h00};
      3'b011:  c = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
      3'b100:  c = '{r: 8'hFF, g: 8'h00, b: 8'h00};
      3'b101:  c = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
      3'b110:  c = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
      3'b111:  c = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
      default: c = '{r: 8'h00, g: 8'h00, b: 8'h00};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/index_frame_reader_vga_timing_gen.sv
// Raster position counters plus the undelayed sync, active-area and
// frame-boundary decodes for the frame memory reader.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = index_frame_reader_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = index_frame_reader_pkg::H_FP,
  parameter int unsigned H_SYNC   = index_frame_reader_pkg::H_SYNC,
  parameter int unsigned H_BP     = index_frame_reader_pkg::H_BP,
  parameter int unsigned V_ACTIVE = index_frame_reader_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = index_frame_reader_pkg::V_FP,
  parameter int unsigned V_SYNC   = index_frame_reader_pkg::V_SYNC,
  parameter int unsigned V_BP     = index_frame_reader_pkg::V_BP
) (
  input  logic clock,
  input  logic reset,
  input  logic pixel_en,
  output logic hs_raw,
  output logic vs_raw,
  output logic active,
  output logic frame_last,
  output logic frame_start
);
  import index_frame_reader_pkg::*;

  localparam logic [CNT_W-1:0] HA     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] VA     = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;

  // Decode the current raster position into raw (undelayed) timing flags.
  always_comb begin
    active     = (hcnt < HA) && (vcnt < VA);
    hs_raw     = !((hcnt >= HS_BEG) && (hcnt < HS_END));
    vs_raw     = !((vcnt >= VS_BEG) && (vcnt < VS_END));
    frame_last = (hcnt == H_LAST) && (vcnt == V_LAST);
  end

  // Advance the raster position and strobe the start of vertical blanking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcnt        <= {CNT_W{1'b0}};
      vcnt        <= {CNT_W{1'b0}};
      frame_start <= 1'b0;
    end else if (pixel_en) begin
      if (hcnt == H_LAST) begin
        hcnt <= {CNT_W{1'b0}};
        if (vcnt == V_LAST) begin
          vcnt <= {CNT_W{1'b0}};
        end else begin
          vcnt <= vcnt + 10'd1;
        end
      end else begin
        hcnt <= hcnt + 10'd1;
      end
      frame_start <= (hcnt == {CNT_W{1'b0}}) && (vcnt == VA);
    end
  end

endmodule

// File: rtl/index_frame_reader.sv
// Read side of the colour-index frame memory: issues raster-order reads, then
// aligns syncs/blank with the returned index and maps it through the palette.
// RD_LATENCY counts the address issue register plus the memory's own read
// pipeline, so syncs are delayed by exactly RD_LATENCY stages before the
// common output register.
module index_frame_reader #(
  parameter int unsigned H_ACTIVE   = index_frame_reader_pkg::H_ACTIVE,
  parameter int unsigned H_FP       = index_frame_reader_pkg::H_FP,
  parameter int unsigned H_SYNC     = index_frame_reader_pkg::H_SYNC,
  parameter int unsigned H_BP       = index_frame_reader_pkg::H_BP,
  parameter int unsigned V_ACTIVE   = index_frame_reader_pkg::V_ACTIVE,
  parameter int unsigned V_FP       = index_frame_reader_pkg::V_FP,
  parameter int unsigned V_SYNC     = index_frame_reader_pkg::V_SYNC,
  parameter int unsigned V_BP       = index_frame_reader_pkg::V_BP,
  parameter int          RD_LATENCY = 2,
  parameter int          ADDR_W     = 19,
  parameter int          IDX_W      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pixel_en,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_rden,
  input  logic [IDX_W-1:0]  mem_rdata,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              frame_start
);
  import index_frame_reader_pkg::*;

  logic                  hs_raw;
  logic                  vs_raw;
  logic                  active;
  logic                  frame_last;
  logic [ADDR_W-1:0]     addr_cnt;
  logic [RD_LATENCY-1:0] hs_dly;
  logic [RD_LATENCY-1:0] vs_dly;
  logic [RD_LATENCY-1:0] act_dly;
  rgb_t                  pix;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clock       (clock),
    .reset       (reset),
    .pixel_en    (pixel_en),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .active      (active),
    .frame_last  (frame_last),
    .frame_start (frame_start)
  );

  // Issue stage: running address (no multiplier), held through blanking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_cnt  <= {ADDR_W{1'b0}};
      mem_raddr <= {ADDR_W{1'b0}};
      mem_rden  <= 1'b0;
    end else if (pixel_en) begin
      mem_rden <= active;
      if (active) begin
        mem_raddr <= addr_cnt;
      end
      if (frame_last) begin
        addr_cnt <= {ADDR_W{1'b0}};
      end else if (active) begin
        addr_cnt <= addr_cnt + ADDR_W'(1'b1);
      end
    end
  end

  // Delay line matching syncs and active flag to the memory read latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs_dly  <= {RD_LATENCY{1'b1}};
      vs_dly  <= {RD_LATENCY{1'b1}};
      act_dly <= {RD_LATENCY{1'b0}};
    end else if (pixel_en) begin
      hs_dly[0]  <= hs_raw;
      vs_dly[0]  <= vs_raw;
      act_dly[0] <= active;
      for (int i = 1; i < RD_LATENCY; i++) begin
        hs_dly[i]  <= hs_dly[i-1];
        vs_dly[i]  <= vs_dly[i-1];
        act_dly[i] <= act_dly[i-1];
      end
    end
  end

  // Palette lookup of the index currently returned by memory.
  always_comb begin
    pix = palette(mem_rdata);
  end

  // Output register: colour only inside the active area, black in blanking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (pixel_en) begin
      vga_hs      <= hs_dly[RD_LATENCY-1];
      vga_vs      <= vs_dly[RD_LATENCY-1];
      vga_blank_n <= act_dly[RD_LATENCY-1];
      if (act_dly[RD_LATENCY-1]) begin
        vga_r <= pix.r;
        vga_g <= pix.g;
        vga_b <= pix.b;
      end else begin
        vga_r <= 8'h00;
        vga_g <= 8'h00;
        vga_b <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_index_frame_reader.sv
// Directed bench: a full 640x480 instance for reset/line/palette/hsync checks
// and a reduced-geometry instance (8x6 visible, 16x11 total) for whole frames.
`timescale 1ns/1ps
module tb_index_frame_reader;

  logic clock = 1'b0;
  logic reset;
  logic pixel_en;
  always #5 clock = ~clock;

  // Full-size instance.
  logic [18:0] raddr_f;
  logic        rden_f;
  logic [2:0]  rdata_f;
  logic [2:0]  mq_f;
  logic [7:0]  r_f, g_f, b_f;
  logic        hs_f, vs_f, bn_f, fs_f;

  // Reduced-geometry instance.
  logic [18:0] raddr_s;
  logic        rden_s;
  logic [2:0]  rdata_s;
  logic [2:0]  mq_s;
  logic [7:0]  r_s, g_s, b_s;
  logic        hs_s, vs_s, bn_s, fs_s;

  int tests  = 0;
  int failed = 0;
  int pos    = 0;

  index_frame_reader dut (
    .clock(clock), .reset(reset), .pixel_en(pixel_en),
    .mem_raddr(raddr_f), .mem_rden(rden_f), .mem_rdata(rdata_f),
    .vga_r(r_f), .vga_g(g_f), .vga_b(b_f),
    .vga_hs(hs_f), .vga_vs(vs_f), .vga_blank_n(bn_f), .frame_start(fs_f)
  );

  index_frame_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .clock(clock), .reset(reset), .pixel_en(pixel_en),
    .mem_raddr(raddr_s), .mem_rden(rden_s), .mem_rdata(rdata_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
    .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bn_s), .frame_start(fs_s)
  );

  // Memory models: index = addr[2:0], one pipeline stage after the issue register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mq_f <= 3'b000;
      mq_s <= 3'b000;
    end else if (pixel_en) begin
      mq_f <= raddr_f[2:0];
      mq_s <= raddr_s[2:0];
    end
  end
  assign rdata_f = mq_f;
  assign rdata_s = mq_s;

  // Reduced-geometry reference: pixel p = p-th tick after reset release.
  localparam int S_HT = 16;
  localparam int S_FT = 176;
  function automatic int s_h(int p); return (p % S_FT) % S_HT; endfunction
  function automatic int s_v(int p); return (p % S_FT) / S_HT; endfunction
  function automatic bit s_act(int p);
    return (p >= 0) && (s_h(p) < 8) && (s_v(p) < 6);
  endfunction
  function automatic int s_raddr(int p);
    if (p < 0) return 0;
    if (s_v(p) >= 6) return 47;
    if (s_h(p) >= 8) return s_v(p) * 8 + 7;
    return s_v(p) * 8 + s_h(p);
  endfunction
  function automatic bit s_hs(int p);
    return (p < 0) || !((s_h(p) >= 10) && (s_h(p) < 13));
  endfunction
  function automatic bit s_vs(int p);
    return (p < 0) || !((s_v(p) >= 7) && (s_v(p) < 9));
  endfunction
  function automatic logic [23:0] s_rgb(int p);
    logic [31:0] a;
    if (!s_act(p)) return 24'h000000;
    a = s_raddr(p);
    return {(a[2] ? 8'hFF : 8'h00), (a[1] ? 8'hFF : 8'h00), (a[0] ? 8'hFF : 8'h00)};
  endfunction
  function automatic bit s_fs(int p);
    return (p >= 0) && ((p % S_FT) == 96);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    if (pixel_en && !reset) pos++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pixel_en = 1'b1;
    repeat (3) step();
    tests++; if ({hs_f, vs_f, bn_f, fs_f} !== 4'b1100) begin failed++; $display("FAIL reset_ctrl: got %b expected 1100", {hs_f, vs_f, bn_f, fs_f}); end
    tests++; if ({r_f, g_f, b_f} !== 24'h000000) begin failed++; $display("FAIL reset_rgb: got %h expected 000000", {r_f, g_f, b_f}); end
    tests++; if ({rden_f, raddr_f} !== 20'h00000) begin failed++; $display("FAIL reset_issue: got %h expected 00000", {rden_f, raddr_f}); end
    reset = 1'b0;
    pos = 0;
    step();
    tests++; if (raddr_f !== 19'd0 || rden_f !== 1'b1) begin failed++; $display("FAIL first_issue: got %0d/%b expected 0/1", raddr_f, rden_f); end
    step();
    tests++; if (raddr_f !== 19'd1) begin failed++; $display("FAIL second_issue: got %0d expected 1", raddr_f); end
    tests++; if (bn_f !== 1'b0 || hs_f !== 1'b1) begin failed++; $display("FAIL early_pins: got %b%b expected 01", bn_f, hs_f); end
    step();
    tests++; if (raddr_f !== 19'd2) begin failed++; $display("FAIL third_issue: got %0d expected 2", raddr_f); end
    tests++; if (bn_f !== 1'b1 || {r_f, g_f, b_f} !== 24'h000000) begin failed++; $display("FAIL pixel0_pins: got %b/%h expected 1/000000", bn_f, {r_f, g_f, b_f}); end
  endtask

  task automatic test_line0();
    int p, exp_a;
    while (pos < 802) begin
      step();
      p = pos - 1;
      exp_a = (p < 640) ? p : ((p < 800) ? 639 : 640 + (p - 800));
      tests++; if (raddr_f !== 19'(exp_a)) begin failed++; $display("FAIL line_raddr p=%0d: got %0d expected %0d", p, raddr_f, exp_a); end
      tests++; if (rden_f !== (p < 640 || p >= 800)) begin failed++; $display("FAIL line_rden p=%0d: got %b", p, rden_f); end
    end
  endtask

  task automatic test_palette_hsync();
    int h, lows, first_low;
    logic [31:0] hv;
    logic [23:0] exp_rgb;
    lows = 0;
    first_low = -1;
    repeat (800) begin
      step();
      h = pos - 3 - 800;
      hv = h;
      exp_rgb = (h < 640) ? {(hv[2] ? 8'hFF : 8'h00), (hv[1] ? 8'hFF : 8'h00), (hv[0] ? 8'hFF : 8'h00)} : 24'h000000;
      tests++; if ({r_f, g_f, b_f} !== exp_rgb) begin failed++; $display("FAIL pin_rgb h=%0d: got %h expected %h", h, {r_f, g_f, b_f}, exp_rgb); end
      tests++; if (bn_f !== (h < 640)) begin failed++; $display("FAIL pin_blank h=%0d: got %b", h, bn_f); end
      tests++; if (hs_f !== !(h >= 656 && h < 752)) begin failed++; $display("FAIL pin_hs h=%0d: got %b", h, hs_f); end
      tests++; if (vs_f !== 1'b1) begin failed++; $display("FAIL pin_vs_line1 h=%0d: got %b expected 1", h, vs_f); end
      if (h == 2) begin
        tests++; if ({r_f, g_f, b_f} !== 24'h00FF00) begin failed++; $display("FAIL green_idx: got %h expected 00ff00", {r_f, g_f, b_f}); end
      end
      if (!hs_f) begin
        if (first_low < 0) first_low = h;
        lows++;
      end
    end
    tests++; if (lows !== 96) begin failed++; $display("FAIL hs_width: got %0d expected 96", lows); end
    tests++; if (first_low !== 656) begin failed++; $display("FAIL hs_start: got %0d expected 656", first_low); end
  endtask

  task automatic test_frame_scan(input bit half);
    int fs_cnt, vs_low, max_addr, steps;
    logic [95:0] snap, now;
    fs_cnt = 0; vs_low = 0; max_addr = 0; snap = '0;
    steps = half ? 704 : 352;
    for (int c = 0; c < steps; c++) begin
      pixel_en = half ? (c % 2 == 0) : 1'b1;
      step();
      now = {raddr_s, rden_s, r_s, g_s, b_s, hs_s, vs_s, bn_s, fs_s,
             raddr_f, rden_f, r_f, g_f, b_f, hs_f, vs_f, bn_f, fs_f};
      if (!pixel_en) begin
        tests++; if (now !== snap) begin failed++; $display("FAIL idle_hold c=%0d: got %h expected %h", c, now, snap); end
      end else begin
        tests++; if (raddr_s !== 19'(s_raddr(pos - 1))) begin failed++; $display("FAIL frame_raddr pos=%0d: got %0d expected %0d", pos, raddr_s, s_raddr(pos - 1)); end
        tests++; if (rden_s !== s_act(pos - 1)) begin failed++; $display("FAIL frame_rden pos=%0d: got %b", pos, rden_s); end
        tests++; if ({r_s, g_s, b_s} !== s_rgb(pos - 3)) begin failed++; $display("FAIL frame_rgb pos=%0d: got %h expected %h", pos, {r_s, g_s, b_s}, s_rgb(pos - 3)); end
        tests++; if ({hs_s, vs_s, bn_s} !== {s_hs(pos - 3), s_vs(pos - 3), s_act(pos - 3)}) begin failed++; $display("FAIL frame_sync pos=%0d: got %b expected %b", pos, {hs_s, vs_s, bn_s}, {s_hs(pos - 3), s_vs(pos - 3), s_act(pos - 3)}); end
        tests++; if (fs_s !== s_fs(pos - 1)) begin failed++; $display("FAIL frame_start pos=%0d: got %b", pos, fs_s); end
        if (fs_s) fs_cnt++;
        if (!vs_s) vs_low++;
        if (rden_s && int'(raddr_s) > max_addr) max_addr = int'(raddr_s);
      end
      snap = now;
    end
    pixel_en = 1'b1;
    tests++; if (fs_cnt !== 2) begin failed++; $display("FAIL fs_count: got %0d expected 2", fs_cnt); end
    tests++; if (vs_low !== 64) begin failed++; $display("FAIL vs_width: got %0d expected 64", vs_low); end
    tests++; if (max_addr !== 47) begin failed++; $display("FAIL last_addr: got %0d expected 47", max_addr); end
  endtask

  task automatic test_reset_midframe();
    pixel_en = 1'b1;
    for (int i = 0; i < S_FT && (pos % S_FT) != 52; i++) step();
    #2;
    reset = 1'b1;
    #1;
    tests++; if ({hs_s, vs_s, bn_s, fs_s, rden_s} !== 5'b11000 || raddr_s !== 19'd0) begin failed++; $display("FAIL async_clr_s: got %b/%0d expected 11000/0", {hs_s, vs_s, bn_s, fs_s, rden_s}, raddr_s); end
    tests++; if ({r_s, g_s, b_s} !== 24'h000000) begin failed++; $display("FAIL async_rgb_s: got %h expected 000000", {r_s, g_s, b_s}); end
    tests++; if ({hs_f, vs_f, bn_f, rden_f} !== 4'b1100 || raddr_f !== 19'd0) begin failed++; $display("FAIL async_clr_f: got %b/%0d expected 1100/0", {hs_f, vs_f, bn_f, rden_f}, raddr_f); end
    step();
    reset = 1'b0;
    pos = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if (raddr_s !== 19'(k) || raddr_f !== 19'(k) || rden_s !== 1'b1) begin failed++; $display("FAIL restart_addr k=%0d: got %0d/%0d expected %0d", k, raddr_s, raddr_f, k); end
    end
    tests++; if (bn_s !== 1'b1 || hs_s !== 1'b1) begin failed++; $display("FAIL restart_pins: got %b%b expected 11", bn_s, hs_s); end
    repeat (180) begin
      step();
      tests++; if (raddr_s !== 19'(s_raddr(pos - 1)) || fs_s !== s_fs(pos - 1)) begin failed++; $display("FAIL restart_scan pos=%0d: got %0d/%b expected %0d", pos, raddr_s, fs_s, s_raddr(pos - 1)); end
      tests++; if ({r_s, g_s, b_s} !== s_rgb(pos - 3)) begin failed++; $display("FAIL restart_rgb pos=%0d: got %h expected %h", pos, {r_s, g_s, b_s}, s_rgb(pos - 3)); end
    end
  endtask

  initial begin
    reset = 1'b1;
    pixel_en = 1'b1;
    test_reset();
    test_line0();
    test_palette_hsync();
    test_frame_scan(1'b0);
    test_frame_scan(1'b1);
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
